interrupt_sequencer: RTL and testbench

Arbitrates one edge-triggered non-maskable source (NMI) and N_IRQ level-sensitive maskable sources for the multi-cycle MIPS core. It raises a single take-interrupt request toward the Controller and holds the winning vector and cause until the Controller acknowledges at an instruction boundary. It tracks in-service state, allowing one level of NMI-over-INT nesting, until return-from-interrupt. It sits between the external INT/NMI/INTD pins and the Controller, and replaces the Controller's direct pin sampling.

---
 rtl/interrupt_sequencer_pkg.sv | 24 ++
 rtl/interrupt_sequencer_irq_priority_encoder.sv | 23 ++
 rtl/interrupt_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_interrupt_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_sequencer_pkg.sv
// Shared definitions for the interrupt sequencer: state encoding, vector defaults,
// cause width and the maskable-vector address helper.
package interrupt_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SVC_INT = 2'd2,
      ST_SVC_NMI = 2'd3
   } state_t;

   localparam int          CAUSE_W          = 3;
   localparam logic [31:0] NMI_VEC_DEF      = 32'h0000_0100;
   localparam logic [31:0] INT_VEC_BASE_DEF = 32'h0000_0180;
   localparam logic [31:0] VEC_STRIDE_DEF   = 32'h0000_0010;

   // Wraps modulo 2^32 by construction.
   function automatic logic [31:0] f_int_vec(input logic [31:0]        base,
                                             input logic [31:0]        stride,
                                             input logic [CAUSE_W-1:0] idx);
      return base + (32'(idx) * stride);
   endfunction

endpackage

// File: rtl/interrupt_sequencer_irq_priority_encoder.sv
// Fixed-priority encoder: reports whether any request is set and the lowest set index.
// Purely combinational.
module irq_priority_encoder
   import interrupt_sequencer_pkg::*;
#(
   parameter int N_IRQ = 4
) (
   input  logic [N_IRQ-1:0]   i_req,
   output logic               o_any,
   output logic [CAUSE_W-1:0] o_idx
);

   always_comb begin
      o_any = |i_req;
      o_idx = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_idx = CAUSE_W'(i);
         end
      end
   end

endmodule

// File: rtl/interrupt_sequencer.sv
// Arbitrates an edge-triggered NMI and N_IRQ masked level IRQs into one take request
// for the Controller, tracking in-service state with one level of NMI-over-INT nesting.
module interrupt_sequencer
   import interrupt_sequencer_pkg::*;
#(
   parameter int          N_IRQ        = 4,
   parameter logic [31:0] NMI_VEC      = NMI_VEC_DEF,
   parameter logic [31:0] INT_VEC_BASE = INT_VEC_BASE_DEF,
   parameter logic [31:0] VEC_STRIDE   = VEC_STRIDE_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               nmi,
   input  logic [N_IRQ-1:0]   int_req,
   input  logic               intd,
   input  logic               mask_we,
   input  logic [N_IRQ-1:0]   mask_wdata,
   input  logic               ina,
   input  logic               eret,
   output logic               irq_take,
   output logic [31:0]        vector,
   output logic               is_nmi,
   output logic [CAUSE_W-1:0] cause,
   output logic               in_service,
   output logic               nested,
   output logic [N_IRQ-1:0]   mask
);

   state_t             r_state;
   logic               r_nmi_d;
   logic               r_nmi_pend;
   logic               r_irq_take;
   logic               r_is_nmi;
   logic               r_in_service;
   logic               r_nested;
   logic               r_from_int;
   logic [CAUSE_W-1:0] r_cause;
   logic [31:0]        r_vector;
   logic [CAUSE_W-1:0] r_sv_cause;
   logic [31:0]        r_sv_vector;
   logic [N_IRQ-1:0]   r_mask;

   logic [N_IRQ-1:0]   w_eligible;
   logic               w_any;
   logic [CAUSE_W-1:0] w_idx;
   logic [31:0]        w_idx_vec;
   logic               w_nmi_edge;
   logic               w_take_nmi;
   logic               w_cur_ok;

   assign w_eligible = int_req & r_mask & {N_IRQ{~intd}};
   assign w_nmi_edge = nmi & ~r_nmi_d;
   assign w_take_nmi = (r_state == ST_REQ) & ina & r_is_nmi;
   assign w_cur_ok   = |(w_eligible & (N_IRQ'(1) << r_cause));
   assign w_idx_vec  = f_int_vec(INT_VEC_BASE, VEC_STRIDE, w_idx);

   irq_priority_encoder #(
      .N_IRQ (N_IRQ)
   ) u_prio (
      .i_req (w_eligible),
      .o_any (w_any),
      .o_idx (w_idx)
   );

   // An edge coinciding with the clearing acknowledge wins, so it re-pends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_nmi_d    <= 1'b0;
         r_nmi_pend <= 1'b0;
         r_mask     <= '0;
      end else begin
         r_nmi_d    <= nmi;
         r_nmi_pend <= w_nmi_edge | (r_nmi_pend & ~w_take_nmi);
         if (mask_we) begin
            r_mask <= mask_wdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_irq_take   <= 1'b0;
         r_is_nmi     <= 1'b0;
         r_in_service <= 1'b0;
         r_nested     <= 1'b0;
         r_from_int   <= 1'b0;
         r_cause      <= '0;
         r_vector     <= '0;
         r_sv_cause   <= '0;
         r_sv_vector  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (r_nmi_pend) begin
                  r_state    <= ST_REQ;
                  r_irq_take <= 1'b1;
                  r_is_nmi   <= 1'b1;
                  r_cause    <= '0;
                  r_vector   <= NMI_VEC;
                  r_from_int <= 1'b0;
               end else if (w_any) begin
                  r_state    <= ST_REQ;
                  r_irq_take <= 1'b1;
                  r_is_nmi   <= 1'b0;
                  r_cause    <= w_idx;
                  r_vector   <= w_idx_vec;
                  r_from_int <= 1'b0;
               end
            end

            ST_REQ: begin
               if (ina) begin
                  r_irq_take   <= 1'b0;
                  r_in_service <= 1'b1;
                  if (r_is_nmi) begin
                     r_state  <= ST_SVC_NMI;
                     r_nested <= r_from_int;
                  end else begin
                     r_state     <= ST_SVC_INT;
                     r_sv_cause  <= r_cause;
                     r_sv_vector <= r_vector;
                  end
               end else if (!r_is_nmi && r_nmi_pend) begin
                  r_is_nmi <= 1'b1;
                  r_cause  <= '0;
                  r_vector <= NMI_VEC;
               end else if (!r_is_nmi && !w_cur_ok) begin
                  if (w_any) begin
                     r_cause  <= w_idx;
                     r_vector <= w_idx_vec;
                  end else if (r_from_int) begin
                     r_state    <= ST_SVC_INT;
                     r_irq_take <= 1'b0;
                     r_cause    <= r_sv_cause;
                     r_vector   <= r_sv_vector;
                  end else begin
                     r_state    <= ST_IDLE;
                     r_irq_take <= 1'b0;
                  end
               end
            end

            // Maskable sources are not arbitrated here; only an NMI can preempt.
            ST_SVC_INT: begin
               if (eret) begin
                  r_state      <= ST_IDLE;
                  r_in_service <= 1'b0;
               end else if (r_nmi_pend) begin
                  r_state    <= ST_REQ;
                  r_irq_take <= 1'b1;
                  r_is_nmi   <= 1'b1;
                  r_cause    <= '0;
                  r_vector   <= NMI_VEC;
                  r_from_int <= 1'b1;
               end
            end

            ST_SVC_NMI: begin
               if (eret) begin
                  r_from_int <= 1'b0;
                  r_nested   <= 1'b0;
                  if (r_nested) begin
                     r_state  <= ST_SVC_INT;
                     r_is_nmi <= 1'b0;
                     r_cause  <= r_sv_cause;
                     r_vector <= r_sv_vector;
                  end else begin
                     r_state      <= ST_IDLE;
                     r_in_service <= 1'b0;
                  end
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign irq_take   = r_irq_take;
   assign vector     = r_vector;
   assign is_nmi     = r_is_nmi;
   assign cause      = r_cause;
   assign in_service = r_in_service;
   assign nested     = r_nested;
   assign mask       = r_mask;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed self-checking bench for interrupt_sequencer: inputs change 1 time unit
// after each rising edge and outputs are checked at that same point.
module tb_interrupt_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        nmi;
   logic [3:0]  int_req;
   logic        intd;
   logic        mask_we;
   logic [3:0]  mask_wdata;
   logic        ina;
   logic        eret;
   logic        irq_take;
   logic [31:0] vector;
   logic        is_nmi;
   logic [2:0]  cause;
   logic        in_service;
   logic        nested;
   logic [3:0]  mask;

   int n_cmp = 0;
   int n_err = 0;

   interrupt_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .nmi        (nmi),
      .int_req    (int_req),
      .intd       (intd),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .ina        (ina),
      .eret       (eret),
      .irq_take   (irq_take),
      .vector     (vector),
      .is_nmi     (is_nmi),
      .cause      (cause),
      .in_service (in_service),
      .nested     (nested),
      .mask       (mask)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_take"}, 32'(irq_take), 32'd0);
      chk({tag, "_vec"}, vector, 32'd0);
      chk({tag, "_isnmi"}, 32'(is_nmi), 32'd0);
      chk({tag, "_cause"}, 32'(cause), 32'd0);
      chk({tag, "_insvc"}, 32'(in_service), 32'd0);
      chk({tag, "_nested"}, 32'(nested), 32'd0);
      chk({tag, "_mask"}, 32'(mask), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; nmi = 1'b0; int_req = '0; intd = 1'b0;
      mask_we = 1'b0; mask_wdata = '0; ina = 1'b0; eret = 1'b0;
      tick(); tick();
      chk_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // Mask write plus request: irq_take two edges later, vector 0x180+2*0x10.
      mask_we = 1'b1; mask_wdata = 4'b0110; int_req = 4'b0100;
      tick();
      mask_we = 1'b0;
      chk("t1_mask", 32'(mask), 32'h6);
      chk("t1_take_early", 32'(irq_take), 32'd0);
      tick();
      chk("t1_take", 32'(irq_take), 32'd1);
      chk("t1_vec", vector, 32'h1A0);
      chk("t1_cause", 32'(cause), 32'd2);
      chk("t1_isnmi", 32'(is_nmi), 32'd0);
      ina = 1'b1;
      tick();
      ina = 1'b0;
      chk("t1_insvc", 32'(in_service), 32'd1);
      chk("t1_take_off", 32'(irq_take), 32'd0);
      eret = 1'b1; int_req = '0;
      tick();
      eret = 1'b0;
      chk("t1_eret_insvc", 32'(in_service), 32'd0);

      // Global disable blocks maskable requests.
      mask_we = 1'b1; mask_wdata = 4'b1111; int_req = 4'b0011; intd = 1'b1;
      tick();
      mask_we = 1'b0;
      tick(); tick();
      chk("t2_intd_block", 32'(irq_take), 32'd0);
      intd = 1'b0;
      tick();
      chk("t2_take", 32'(irq_take), 32'd1);
      chk("t2_cause", 32'(cause), 32'd0);
      chk("t2_vec", vector, 32'h180);
      ina = 1'b1;
      tick();
      ina = 1'b0; int_req = 4'b0010; eret = 1'b1;
      tick();
      eret = 1'b0;
      tick();
      chk("t3_req_cause", 32'(cause), 32'd1);
      chk("t3_req_vec", vector, 32'h190);

      // NMI retargets a pending INT request.
      nmi = 1'b1;
      tick();
      nmi = 1'b0;
      tick();
      chk("t3_isnmi", 32'(is_nmi), 32'd1);
      chk("t3_vec", vector, 32'h100);
      chk("t3_cause", 32'(cause), 32'd0);
      chk("t3_take", 32'(irq_take), 32'd1);
      ina = 1'b1;
      tick();
      ina = 1'b0;
      chk("t3_nested", 32'(nested), 32'd0);
      chk("t3_insvc", 32'(in_service), 32'd1);
      chk("t3_take_off", 32'(irq_take), 32'd0);
      eret = 1'b1; int_req = '0;
      tick();
      eret = 1'b0;
      tick(); tick();
      chk("t3_pend_cleared", 32'(irq_take), 32'd0);
      chk("t3_idle_insvc", 32'(in_service), 32'd0);

      // NMI nests over an INT handler and restores it on return.
      int_req = 4'b1000;
      tick();
      chk("t4_int_vec", vector, 32'h1B0);
      ina = 1'b1;
      tick();
      ina = 1'b0; int_req = '0;
      nmi = 1'b1;
      tick();
      nmi = 1'b0;
      tick();
      chk("t4_take", 32'(irq_take), 32'd1);
      chk("t4_vec", vector, 32'h100);
      chk("t4_isnmi", 32'(is_nmi), 32'd1);
      ina = 1'b1;
      tick();
      ina = 1'b0;
      chk("t4_nested", 32'(nested), 32'd1);
      eret = 1'b1;
      tick();
      eret = 1'b0;
      chk("t4_ret_vec", vector, 32'h1B0);
      chk("t4_ret_cause", 32'(cause), 32'd3);
      chk("t4_ret_isnmi", 32'(is_nmi), 32'd0);
      chk("t4_ret_nested", 32'(nested), 32'd0);
      chk("t4_ret_insvc", 32'(in_service), 32'd1);
      eret = 1'b1;
      tick();
      eret = 1'b0;
      chk("t4_idle_insvc", 32'(in_service), 32'd0);
      chk("t4_idle_take", 32'(irq_take), 32'd0);

      // Withdrawn request: retarget to another line, then drop to IDLE.
      int_req = 4'b1100;
      tick();
      chk("t5_cause", 32'(cause), 32'd2);
      int_req = 4'b1000;
      tick();
      chk("t5_retarget_cause", 32'(cause), 32'd3);
      chk("t5_retarget_vec", vector, 32'h1B0);
      chk("t5_retarget_take", 32'(irq_take), 32'd1);
      int_req = '0;
      tick();
      chk("t5_drop_take", 32'(irq_take), 32'd0);
      ina = 1'b1;
      tick();
      ina = 1'b0;
      chk("t5_ina_ignored_insvc", 32'(in_service), 32'd0);
      tick();
      chk("t5_ina_ignored_take", 32'(irq_take), 32'd0);

      // NMI edge during NMI service pends; re-requested two edges after eret.
      nmi = 1'b1;
      tick();
      nmi = 1'b0;
      tick();
      ina = 1'b1;
      tick();
      ina = 1'b0;
      chk("t6_svc_nmi", 32'(in_service), 32'd1);
      nmi = 1'b1;
      tick();
      nmi = 1'b0; eret = 1'b1;
      tick();
      eret = 1'b0;
      chk("t6_eret_take0", 32'(irq_take), 32'd0);
      tick();
      chk("t6_rereq_take", 32'(irq_take), 32'd1);
      chk("t6_rereq_isnmi", 32'(is_nmi), 32'd1);
      ina = 1'b1;
      tick();
      ina = 1'b0;

      // Asynchronous reset in the middle of NMI service.
      int_req = 4'b0100;
      #2 rst_n = 1'b0;
      #1;
      chk_all_zero("arst");
      #10 rst_n = 1'b1;
      tick(); tick(); tick();
      chk("arst_no_req", 32'(irq_take), 32'd0);
      chk("arst_mask", 32'(mask), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
